load_pipeline: RTL and testbench



---
 rtl/load_pipeline_pkg.sv | 27 ++
 rtl/load_pipeline_alu.sv | 28 ++
 rtl/load_pipeline.sv | 105 ++++++++++
 tb/tb_load_pipeline.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/load_pipeline_pkg.sv
// load_pipeline_pkg: shared widths, combine-function encoding and the stage
// record carried down the load pipeline.
package load_pipeline_pkg;

  localparam int DW_DEF = 16;  // data / register width
  localparam int AW_DEF = 8;   // memory address width
  localparam int RW_DEF = 4;   // register index width

  typedef enum logic [1:0] {
    FUNC_LOAD = 2'd0,  // z = mem
    FUNC_ADD  = 2'd1,  // z = mem + R[rs]
    FUNC_SUB  = 2'd2,  // z = mem - R[rs]
    FUNC_XOR  = 2'd3   // z = mem ^ R[rs]
  } func_e;

  // One record per stage. 'val' is unused in S1, holds the memory word in S2
  // and the combined result in S3.
  typedef struct packed {
    logic              valid;
    logic [RW_DEF-1:0] rs;
    logic [RW_DEF-1:0] rd;
    func_e             func;
    logic [AW_DEF-1:0] addr;
    logic [DW_DEF-1:0] val;
  } stage_t;

endpackage

// File: rtl/load_pipeline_alu.sv
// load_pipeline_alu: combinational combine of a loaded word with a register
// operand. Arithmetic wraps modulo 2**DW.
//   func_i : combine function
//   md_i   : word read from data memory
//   opnd_i : forwarded register operand (ignored for FUNC_LOAD)
//   z_o    : result
module load_pipeline_alu
  import load_pipeline_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  func_e         func_i,
  input  logic [DW-1:0] md_i,
  input  logic [DW-1:0] opnd_i,
  output logic [DW-1:0] z_o
);

  always_comb begin
    z_o = md_i;
    case (func_i)
      FUNC_LOAD: z_o = md_i;
      FUNC_ADD:  z_o = md_i + opnd_i;
      FUNC_SUB:  z_o = md_i - opnd_i;
      FUNC_XOR:  z_o = md_i ^ opnd_i;
    endcase
  end

endmodule

// File: rtl/load_pipeline.sv
// load_pipeline: four-stage load pipeline. S1 latches the request, S2 reads
// data memory, S3 combines with a forwarded register operand, and the
// retire edge writes the register bank and presents wb_valid/wb_rd/z.
//   clk, rst             : clock, synchronous active-high reset
//   hold                 : freeze all stages (wb_valid forced low)
//   req_*                : load request (valid, rs, rd, func, addr)
//   mem_we/waddr/wdata   : external data-memory write port (ignores hold)
//   wb_valid, wb_rd, z   : retired result
// Stage records are sized by the package; keep parameters at package defaults.
module load_pipeline
  import load_pipeline_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF,
  parameter int RW = RW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hold,
  input  logic          req_valid,
  input  logic [RW-1:0] req_rs,
  input  logic [RW-1:0] req_rd,
  input  logic [1:0]    req_func,
  input  logic [AW-1:0] req_addr,
  input  logic          mem_we,
  input  logic [AW-1:0] mem_waddr,
  input  logic [DW-1:0] mem_wdata,
  output logic          wb_valid,
  output logic [RW-1:0] wb_rd,
  output logic [DW-1:0] z
);

  stage_t s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rf_q  [2**RW];

  logic [DW-1:0] opnd, alu_z;
  logic          wb_valid_q;
  logic [RW-1:0] wb_rd_q;
  logic [DW-1:0] z_q;

  // Only the instruction in S3 can be younger than the regbank contents;
  // anything older has already retired.
  assign opnd = (s3_q.valid && s3_q.rd == s2_q.rs) ? s3_q.val : rf_q[s2_q.rs];

  load_pipeline_alu #(.DW(DW)) u_alu (
    .func_i (s2_q.func),
    .md_i   (s2_q.val),
    .opnd_i (opnd),
    .z_o    (alu_z)
  );

  always_comb begin
    s1_d       = '0;
    s1_d.valid = req_valid;
    s1_d.rs    = req_rs;
    s1_d.rd    = req_rd;
    s1_d.func  = func_e'(req_func);
    s1_d.addr  = req_addr;

    s2_d       = s1_q;
    s2_d.val   = mem_q[s1_q.addr];

    s3_d       = s2_q;
    s3_d.val   = alu_z;
  end

  // Read in S1->S2 sees the pre-write contents at a colliding edge.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst && !hold && s3_q.valid) rf_q[s3_q.rd] <= s3_q.val;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q       <= '0;
      s2_q       <= '0;
      s3_q       <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      z_q        <= '0;
    end else if (hold) begin
      // S3 stays put, so its result retires once when hold drops.
      wb_valid_q <= 1'b0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      s3_q       <= s3_d;
      wb_valid_q <= s3_q.valid;
      if (s3_q.valid) begin
        wb_rd_q <= s3_q.rd;
        z_q     <= s3_q.val;
      end
    end
  end

  assign wb_valid = wb_valid_q;
  assign wb_rd    = wb_rd_q;
  assign z        = z_q;

endmodule

// File: tb/tb_load_pipeline.sv
// Scoreboard bench for load_pipeline: issue() pushes the hand-computed
// result, a negedge monitor pops and compares on every wb_valid.
module tb_load_pipeline;
  import load_pipeline_pkg::*;

  localparam int DW = 16;
  localparam int AW = 8;
  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          rst, hold, req_valid, mem_we;
  logic [RW-1:0] req_rs, req_rd;
  logic [1:0]    req_func;
  logic [AW-1:0] req_addr, mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic          wb_valid;
  logic [RW-1:0] wb_rd;
  logic [DW-1:0] z;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [RW-1:0] rd;
    logic [DW-1:0] z;
  } exp_t;
  exp_t sb[$];

  load_pipeline dut (
    .clk(clk), .rst(rst), .hold(hold),
    .req_valid(req_valid), .req_rs(req_rs), .req_rd(req_rd),
    .req_func(req_func), .req_addr(req_addr),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .z(z)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every retirement must match the oldest outstanding expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (wb_valid) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_wb: got rd=%0d z=0x%0h, want no retirement", wb_rd, z);
      end else begin
        e = sb.pop_front();
        chk("wb_rd", 32'(wb_rd), 32'(e.rd));
        chk("wb_z", 32'(z), 32'(e.z));
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got no finish, want finish before 100us");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    mem_we    = 1'b0;
    repeat (n) tick();
  endtask

  task automatic memw(input logic [AW-1:0] a, input logic [DW-1:0] d);
    mem_we    = 1'b1;
    mem_waddr = a;
    mem_wdata = d;
    tick();
    mem_we    = 1'b0;
  endtask

  task automatic issue(input logic [1:0] f, input logic [RW-1:0] rs, input logic [RW-1:0] rd,
                       input logic [AW-1:0] a, input logic [DW-1:0] exp, input bit push);
    exp_t e;
    req_valid = 1'b1;
    req_func  = f;
    req_rs    = rs;
    req_rd    = rd;
    req_addr  = a;
    if (push) begin
      e.rd = rd;
      e.z  = exp;
      sb.push_back(e);
    end
    tick();
    req_valid = 1'b0;
  endtask

  // mem[200] holds 0, so load+R[r] into scratch R15 exposes R[r] on z.
  task automatic readback(input logic [RW-1:0] r, input logic [DW-1:0] exp);
    issue(2'd1, r, 4'd15, 8'd200, exp, 1'b1);
  endtask

  initial begin
    rst = 1'b1; hold = 1'b0; req_valid = 1'b0; mem_we = 1'b0;
    req_rs = '0; req_rd = '0; req_func = '0; req_addr = '0;
    mem_waddr = '0; mem_wdata = '0;
    repeat (2) tick();
    chk("reset_wb_valid", 32'(wb_valid), 32'd0);
    chk("reset_wb_rd", 32'(wb_rd), 32'd0);
    chk("reset_z", 32'(z), 32'd0);
    rst = 1'b0;

    // 1: plain load, then confirm the regbank write.
    memw(8'd125, 16'h0100);
    issue(2'd0, 4'd0, 4'd1, 8'd125, 16'h0100, 1'b1);
    memw(8'd200, 16'h0000);
    idle(3);
    readback(4'd1, 16'h0100);
    idle(4);

    // 2: preload R[k]=k, then load+R[5]; readback is forwarded from S3.
    for (int k = 0; k < 16; k++) memw(AW'(40 + k), DW'(k));
    for (int k = 0; k < 16; k++) issue(2'd0, 4'd0, RW'(k), AW'(40 + k), DW'(k), 1'b1);
    memw(8'd126, 16'h0010);
    issue(2'd1, 4'd5, 4'd2, 8'd126, 16'h0015, 1'b1);
    readback(4'd2, 16'h0015);
    idle(4);

    // 3: dependent back-to-back chain, forward path then regbank path.
    memw(8'd10, 16'd7);
    memw(8'd11, 16'd1);
    issue(2'd0, 4'd0, 4'd3, 8'd10, 16'd7, 1'b1);
    issue(2'd1, 4'd3, 4'd4, 8'd11, 16'd8, 1'b1);
    issue(2'd1, 4'd3, 4'd5, 8'd11, 16'd8, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_burst_valid", 32'(wb_valid), 32'd1);
    end
    idle(2);

    // 4: subtract wrap and xor.
    memw(8'd12, 16'h0000);
    issue(2'd2, 4'd6, 4'd7, 8'd12, 16'hFFFA, 1'b1);
    memw(8'd13, 16'h00FF);
    issue(2'd3, 4'd6, 4'd8, 8'd13, 16'h00F9, 1'b1);
    idle(4);

    // 5: memory write at the same edge as the S1->S2 read returns old data;
    //    the request repeated that cycle sees the new data.
    memw(8'd20, 16'h1111);
    issue(2'd0, 4'd0, 4'd9, 8'd20, 16'h1111, 1'b1);
    mem_we = 1'b1; mem_waddr = 8'd20; mem_wdata = 16'hAAAA;
    issue(2'd0, 4'd0, 4'd9, 8'd20, 16'hAAAA, 1'b1);
    mem_we = 1'b0;
    idle(4);

    // 6a: hold two cycles with the request in S2; a request presented during
    //     hold must be dropped.
    issue(2'd1, 4'd11, 4'd11, 8'd125, 16'h010B, 1'b1);
    tick();
    hold = 1'b1;
    req_valid = 1'b1; req_func = 2'd0; req_rd = 4'd12; req_rs = 4'd0; req_addr = 8'd125;
    tick();
    chk("hold_wb_valid_1", 32'(wb_valid), 32'd0);
    tick();
    chk("hold_wb_valid_2", 32'(wb_valid), 32'd0);
    hold = 1'b0;
    req_valid = 1'b0;
    tick();
    chk("hold_release_0", 32'(wb_valid), 32'd0);
    tick();
    chk("hold_retire", 32'(wb_valid), 32'd1);
    tick();
    chk("hold_once", 32'(wb_valid), 32'd0);
    readback(4'd11, 16'h010B);
    idle(4);

    // 6b: reset with three loads in flight: nothing retires, regs untouched.
    issue(2'd0, 4'd0, 4'd12, 8'd125, 16'h0100, 1'b0);
    issue(2'd0, 4'd0, 4'd13, 8'd125, 16'h0100, 1'b0);
    issue(2'd0, 4'd0, 4'd14, 8'd125, 16'h0100, 1'b0);
    rst = 1'b1;
    tick();
    chk("midrst_wb_valid", 32'(wb_valid), 32'd0);
    chk("midrst_wb_rd", 32'(wb_rd), 32'd0);
    chk("midrst_z", 32'(z), 32'd0);
    rst = 1'b0;
    idle(5);
    readback(4'd12, 16'd12);
    readback(4'd13, 16'd13);
    readback(4'd14, 16'd14);
    idle(6);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
